// File: rtl/z80_mapper_bridge.sv
// z80_mapper_bridge
//   Turns asynchronous Z80 bus cycles into clk_108m-domain request levels for
//   the SDRAM arbiter, and hosts the MSX memory-mapper segment registers
//   (I/O ports FCh-FFh).
// Ports:
//   clk_108m, reset_n          system clock, async active-low reset
//   z80_addr/z80_din           Z80 address and write data (asynchronous)
//   z80_*_n strobes            Z80 control strobes (asynchronous, active-low)
//   slot_sel_i-style slot_sel  address decodes to the mapper slot
//   mapper_dout                read byte returned by the arbiter
//   mapper_addr/mapper_din     registered {segment, addr[13:0]} and write byte
//   mapper_read/mapper_write   request levels, one continuous level per Z80 cycle
//   refresh                    low during a Z80 refresh cycle
//   z80_dout/z80_dout_en       read data back to the Z80 and its bus enable
//   z80_wait_n                 Z80 WAIT, held low while a memory read is pending
module z80_mapper_bridge #(
    parameter int SEG_BITS = 8,
    parameter int RD_WAIT  = 48
) (
    input  logic        clk_108m,
    input  logic        reset_n,
    input  logic [15:0] z80_addr,
    input  logic [7:0]  z80_din,
    input  logic        z80_mreq_n,
    input  logic        z80_iorq_n,
    input  logic        z80_rd_n,
    input  logic        z80_wr_n,
    input  logic        z80_rfsh_n,
    input  logic        z80_m1_n,
    input  logic        slot_sel,
    input  logic [7:0]  mapper_dout,
    output logic [21:0] mapper_addr,
    output logic [7:0]  mapper_din,
    output logic        mapper_read,
    output logic        mapper_write,
    output logic        refresh,
    output logic [7:0]  z80_dout,
    output logic        z80_dout_en,
    output logic        z80_wait_n
);

    localparam int CNT_W = $clog2(RD_WAIT + 1);

    // Synchronizer bit positions
    localparam int S_MREQ = 0;
    localparam int S_IORQ = 1;
    localparam int S_RD   = 2;
    localparam int S_WR   = 3;
    localparam int S_RFSH = 4;
    localparam int S_M1   = 5;

    typedef enum logic [2:0] {
        IDLE,
        MEM_RD,
        MEM_WR,
        IO_RD,
        IO_WR,
        RFSH
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          sync1_q, sync2_q;
    logic [SEG_BITS-1:0] seg_q [4];
    logic [SEG_BITS-1:0] seg_d [4];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [21:0]         addr_q, addr_d;
    logic [7:0]          din_q, din_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic                refresh_q, refresh_d;
    logic [7:0]          dout_q, dout_d;
    logic                dout_en_q, dout_en_d;
    logic                wait_q, wait_d;

    logic                mreq_n_s, iorq_n_s, rd_n_s, wr_n_s, rfsh_n_s, m1_n_s;
    logic                io_hit;
    logic [SEG_BITS-1:0] seg_page, seg_port;
    logic [7:0]          seg_addr_ext, seg_rd_ext;

    assign mreq_n_s = sync2_q[S_MREQ];
    assign iorq_n_s = sync2_q[S_IORQ];
    assign rd_n_s   = sync2_q[S_RD];
    assign wr_n_s   = sync2_q[S_WR];
    assign rfsh_n_s = sync2_q[S_RFSH];
    assign m1_n_s   = sync2_q[S_M1];

    // Strobes idle high, so the synchronizers reset to the inactive level.
    always_ff @(posedge clk_108m or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {z80_m1_n, z80_rfsh_n, z80_wr_n, z80_rd_n, z80_iorq_n, z80_mreq_n};
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_108m or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            seg_q[0]  <= SEG_BITS'(3);
            seg_q[1]  <= SEG_BITS'(2);
            seg_q[2]  <= SEG_BITS'(1);
            seg_q[3]  <= SEG_BITS'(0);
            cnt_q     <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            refresh_q <= 1'b1;
            dout_q    <= '0;
            dout_en_q <= 1'b0;
            wait_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            read_q    <= read_d;
            write_q   <= write_d;
            refresh_q <= refresh_d;
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
            wait_q    <= wait_d;
        end
    end

    // The address bus is stable once a strobe has been synchronized, so the
    // raw bus is sampled directly on the transition out of IDLE.
    always_comb begin
        io_hit   = !iorq_n_s && m1_n_s && (z80_addr[7:2] == 6'b111111);
        seg_page = seg_q[z80_addr[15:14]];
        seg_port = seg_q[z80_addr[1:0]];

        // Memory address zero-extends the segment; I/O readback one-fills it.
        seg_addr_ext                = '0;
        seg_addr_ext[SEG_BITS-1:0]  = seg_page;
        seg_rd_ext                  = '1;
        seg_rd_ext[SEG_BITS-1:0]    = seg_port;

        state_d   = state_q;
        seg_d     = seg_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        din_d     = din_q;
        read_d    = read_q;
        write_d   = write_q;
        refresh_d = refresh_q;
        dout_d    = dout_q;
        dout_en_d = dout_en_q;
        wait_d    = wait_q;

        case (state_q)
            IDLE: begin
                if (!mreq_n_s && !rfsh_n_s) begin
                    state_d   = RFSH;
                    refresh_d = 1'b0;
                end else if (!mreq_n_s && !rd_n_s && slot_sel) begin
                    state_d = MEM_RD;
                    read_d  = 1'b1;
                    wait_d  = 1'b0;
                    cnt_d   = '0;
                    addr_d  = {seg_addr_ext, z80_addr[13:0]};
                end else if (!mreq_n_s && !wr_n_s && slot_sel) begin
                    state_d = MEM_WR;
                    write_d = 1'b1;
                    addr_d  = {seg_addr_ext, z80_addr[13:0]};
                    din_d   = z80_din;
                end else if (io_hit && !rd_n_s) begin
                    state_d   = IO_RD;
                    dout_d    = seg_rd_ext;
                    dout_en_d = 1'b1;
                end else if (io_hit && !wr_n_s) begin
                    state_d                = IO_WR;
                    seg_d[z80_addr[1:0]]   = z80_din[SEG_BITS-1:0];
                end
            end
            MEM_RD: begin
                if (rd_n_s) begin
                    state_d   = IDLE;
                    read_d    = 1'b0;
                    wait_d    = 1'b1;
                    dout_en_d = 1'b0;
                end else if (cnt_q != CNT_W'(RD_WAIT)) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!wait_q) begin
                    // Counter saturates; the wait_q guard latches data once.
                    wait_d    = 1'b1;
                    dout_d    = mapper_dout;
                    dout_en_d = 1'b1;
                end
            end
            MEM_WR: begin
                if (wr_n_s) begin
                    state_d = IDLE;
                    write_d = 1'b0;
                end
            end
            IO_RD: begin
                if (rd_n_s) begin
                    state_d   = IDLE;
                    dout_en_d = 1'b0;
                end
            end
            IO_WR: begin
                if (wr_n_s) state_d = IDLE;
            end
            RFSH: begin
                if (mreq_n_s || rfsh_n_s) begin
                    state_d   = IDLE;
                    refresh_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mapper_addr  = addr_q;
    assign mapper_din   = din_q;
    assign mapper_read  = read_q;
    assign mapper_write = write_q;
    assign refresh      = refresh_q;
    assign z80_dout     = dout_q;
    assign z80_dout_en  = dout_en_q;
    assign z80_wait_n   = wait_q;

endmodule

// File: tb/tb_z80_mapper_bridge.sv
module tb_z80_mapper_bridge;

    localparam int RD_WAIT = 48;

    logic        clk_108m = 1'b0;
    logic        reset_n  = 1'b0;
    logic [15:0] z80_addr = '0;
    logic [7:0]  z80_din  = '0;
    logic        z80_mreq_n = 1'b1, z80_iorq_n = 1'b1, z80_rd_n = 1'b1;
    logic        z80_wr_n = 1'b1, z80_rfsh_n = 1'b1, z80_m1_n = 1'b1;
    logic        slot_sel = 1'b0;
    logic [7:0]  mapper_dout = '0;

    logic [21:0] a0, a1;
    logic [7:0]  din0, din1, dout0, dout1;
    logic        rd0, rd1, wr0, wr1, rf0, rf1, en0, en1, wt0, wt1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_108m = ~clk_108m;

    z80_mapper_bridge #(.SEG_BITS(8), .RD_WAIT(RD_WAIT)) dut (
        .clk_108m(clk_108m), .reset_n(reset_n), .z80_addr(z80_addr), .z80_din(z80_din),
        .z80_mreq_n(z80_mreq_n), .z80_iorq_n(z80_iorq_n), .z80_rd_n(z80_rd_n),
        .z80_wr_n(z80_wr_n), .z80_rfsh_n(z80_rfsh_n), .z80_m1_n(z80_m1_n),
        .slot_sel(slot_sel), .mapper_dout(mapper_dout), .mapper_addr(a0),
        .mapper_din(din0), .mapper_read(rd0), .mapper_write(wr0), .refresh(rf0),
        .z80_dout(dout0), .z80_dout_en(en0), .z80_wait_n(wt0)
    );

    z80_mapper_bridge #(.SEG_BITS(6), .RD_WAIT(RD_WAIT)) dut6 (
        .clk_108m(clk_108m), .reset_n(reset_n), .z80_addr(z80_addr), .z80_din(z80_din),
        .z80_mreq_n(z80_mreq_n), .z80_iorq_n(z80_iorq_n), .z80_rd_n(z80_rd_n),
        .z80_wr_n(z80_wr_n), .z80_rfsh_n(z80_rfsh_n), .z80_m1_n(z80_m1_n),
        .slot_sel(slot_sel), .mapper_dout(mapper_dout), .mapper_addr(a1),
        .mapper_din(din1), .mapper_read(rd1), .mapper_write(wr1), .refresh(rf1),
        .z80_dout(dout1), .z80_dout_en(en1), .z80_wait_n(wt1)
    );

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_108m);
        #1;
    endtask

    task automatic bus_idle();
        z80_mreq_n = 1'b1; z80_iorq_n = 1'b1; z80_rd_n = 1'b1;
        z80_wr_n = 1'b1; z80_rfsh_n = 1'b1; z80_m1_n = 1'b1; slot_sel = 1'b0;
    endtask

    task automatic io_out(input logic [7:0] port, input logic [7:0] data);
        z80_addr = {8'h00, port}; z80_din = data;
        z80_iorq_n = 1'b0; z80_wr_n = 1'b0;
        cycles(4);
        bus_idle();
        cycles(4);
    endtask

    task automatic io_in_start(input logic [7:0] port);
        z80_addr = {8'h00, port};
        z80_iorq_n = 1'b0; z80_rd_n = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_seg [4];
        exp_seg[0] = 8'h03; exp_seg[1] = 8'h02; exp_seg[2] = 8'h01; exp_seg[3] = 8'h00;
        vectors++;
        if ({rf0, wt0, rd0, wr0, en0} !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_strobes: got rf/wt/rd/wr/en=%b want 11000", {rf0, wt0, rd0, wr0, en0});
        end
        vectors++;
        if (a0 !== 22'h0 || din0 !== 8'h0 || dout0 !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_data: got addr=%h din=%h dout=%h want 0/0/0", a0, din0, dout0);
        end
        for (int i = 0; i < 4; i++) begin
            io_in_start(8'hFC + 8'(i));
            cycles(3);
            vectors++;
            if (en0 !== 1'b1 || dout0 !== exp_seg[i]) begin
                miscompares++;
                $display("FAIL reset_seg%0d: got en=%b dout=%h want 1/%h", i, en0, dout0, exp_seg[i]);
            end
            bus_idle();
            cycles(3);
            vectors++;
            if (en0 !== 1'b0) begin
                miscompares++;
                $display("FAIL io_rd_release%0d: got en=%b want 0", i, en0);
            end
        end
    endtask

    task automatic test_mem_write();
        io_out(8'hFE, 8'h25);
        io_in_start(8'hFE);
        cycles(3);
        vectors++;
        if (dout0 !== 8'h25) begin
            miscompares++;
            $display("FAIL seg2_write: got %h want 25", dout0);
        end
        bus_idle();
        cycles(3);

        z80_addr = 16'h8123; z80_din = 8'h5A; slot_sel = 1'b1;
        z80_mreq_n = 1'b0; z80_wr_n = 1'b0;
        cycles(2);
        vectors++;
        if (wr0 !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_early: got %b want 0 after 2 cycles", wr0);
        end
        cycles(1);
        vectors++;
        if (wr0 !== 1'b1 || a0 !== 22'h094123 || din0 !== 8'h5A || rd0 !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rise: got wr=%b addr=%h din=%h rd=%b want 1/094123/5a/0", wr0, a0, din0, rd0);
        end
        cycles(5);
        vectors++;
        if (wr0 !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_hold: got %b want 1", wr0);
        end
        bus_idle();
        cycles(2);
        vectors++;
        if (wr0 !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_fall_early: got %b want 1 after 2 cycles", wr0);
        end
        cycles(1);
        vectors++;
        if (wr0 !== 1'b0 || a0 !== 22'h094123 || din0 !== 8'h5A) begin
            miscompares++;
            $display("FAIL wr_fall: got wr=%b addr=%h din=%h want 0/094123/5a", wr0, a0, din0);
        end
    endtask

    task automatic test_mem_read();
        int n;
        mapper_dout = 8'hA7;
        z80_addr = 16'hC000; slot_sel = 1'b1;
        z80_mreq_n = 1'b0; z80_rd_n = 1'b0;
        cycles(2);
        vectors++;
        if (rd0 !== 1'b0 || wt0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_early: got rd=%b wait_n=%b want 0/1", rd0, wt0);
        end
        cycles(1);
        vectors++;
        if (rd0 !== 1'b1 || wt0 !== 1'b0 || a0 !== 22'h0 || en0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_rise: got rd=%b wait_n=%b addr=%h en=%b want 1/0/000000/0", rd0, wt0, a0, en0);
        end
        n = 0;
        while (wt0 !== 1'b1 && n < 200) begin
            cycles(1);
            n++;
        end
        vectors++;
        if (n != RD_WAIT + 1) begin
            miscompares++;
            $display("FAIL wait_len: got %0d cycles want %0d", n, RD_WAIT + 1);
        end
        vectors++;
        if (dout0 !== 8'hA7 || en0 !== 1'b1 || rd0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_data: got dout=%h en=%b rd=%b want a7/1/1", dout0, en0, rd0);
        end
        bus_idle();
        cycles(3);
        vectors++;
        if (rd0 !== 1'b0 || en0 !== 1'b0 || wt0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_end: got rd=%b en=%b wait_n=%b want 0/0/1", rd0, en0, wt0);
        end
    endtask

    task automatic test_refresh();
        z80_addr = 16'h0042; slot_sel = 1'b1;
        z80_mreq_n = 1'b0; z80_rfsh_n = 1'b0;
        cycles(3);
        vectors++;
        if (rf0 !== 1'b0 || rd0 !== 1'b0 || wr0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rfsh_start: got rf=%b rd=%b wr=%b want 0/0/0", rf0, rd0, wr0);
        end
        cycles(6);
        vectors++;
        if (rf0 !== 1'b0 || rd0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rfsh_hold: got rf=%b rd=%b want 0/0", rf0, rd0);
        end
        bus_idle();
        cycles(3);
        vectors++;
        if (rf0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rfsh_end: got %b want 1", rf0);
        end
    endtask

    task automatic test_seg6();
        io_out(8'hFC, 8'hFF);
        io_in_start(8'hFC);
        cycles(3);
        vectors++;
        if (dout1 !== 8'hFF || dout0 !== 8'hFF) begin
            miscompares++;
            $display("FAIL seg6_in: got dut6=%h dut8=%h want ff/ff", dout1, dout0);
        end
        bus_idle();
        cycles(3);
        z80_addr = 16'h0000; z80_din = 8'h11; slot_sel = 1'b1;
        z80_mreq_n = 1'b0; z80_wr_n = 1'b0;
        cycles(3);
        vectors++;
        if (a1[21:14] !== 8'h3F || a0[21:14] !== 8'hFF || wr1 !== 1'b1) begin
            miscompares++;
            $display("FAIL seg6_addr: got dut6=%h dut8=%h wr=%b want 3f/ff/1", a1[21:14], a0[21:14], wr1);
        end
        bus_idle();
        cycles(3);
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] exp_seg [4];
        exp_seg[0] = 8'h03; exp_seg[1] = 8'h02; exp_seg[2] = 8'h01; exp_seg[3] = 8'h00;
        z80_addr = 16'h8000; slot_sel = 1'b1;
        z80_mreq_n = 1'b0; z80_rd_n = 1'b0;
        cycles(10);
        vectors++;
        if (rd0 !== 1'b1 || wt0 !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset_rd: got rd=%b wait_n=%b want 1/0", rd0, wt0);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (rd0 !== 1'b0 || wt0 !== 1'b1 || a0 !== 22'h0 || en0 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got rd=%b wait_n=%b addr=%h en=%b want 0/1/0/0", rd0, wt0, a0, en0);
        end
        cycles(2);
        bus_idle();
        reset_n = 1'b1;
        cycles(3);
        for (int i = 0; i < 4; i++) begin
            io_in_start(8'hFC + 8'(i));
            cycles(3);
            vectors++;
            if (dout0 !== exp_seg[i] || rd0 !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_seg%0d: got dout=%h rd=%b want %h/0", i, dout0, rd0, exp_seg[i]);
            end
            bus_idle();
            cycles(3);
        end
    endtask

    initial begin
        bus_idle();
        cycles(3);
        reset_n = 1'b1;
        cycles(2);
        test_reset();
        test_mem_write();
        test_mem_read();
        test_refresh();
        test_seg6();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
